// File: rtl/sync_handshake_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack clock-crossing channel among N requesters.
// The far-domain ack is synchronized before it steers the handshake sequencer.
module sync_handshake_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned W           = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         src_valid,
  input  logic [N*W-1:0]       src_data,
  output logic [N-1:0]         src_ready,
  output logic                 xfer_req,
  output logic [W-1:0]         xfer_data,
  input  logic                 xfer_ack,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 done,
  output logic                 timeout_err
);

  localparam int unsigned IW    = $clog2(N);
  localparam int unsigned CW    = IW + 1;
  localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic [IW-1:0]          rr;
  logic [TW-1:0]          timer;
  logic                   found;
  logic [IW-1:0]          winner;
  logic [CW-1:0]          cand;
  logic [W-1:0]           word;

  // Ack synchronizer: only ack_s is ever seen by the sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], xfer_ack};
  end
  assign ack_s = sync_q[SYNC_STAGES-1];

  // Round-robin search starting just after the last winner, wrapping at N
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = {1'b0, rr} + CW'(k);
      if (cand >= CW'(N)) cand = cand - CW'(N);
      if (!found && src_valid[IW'(cand)]) begin
        found  = 1'b1;
        winner = IW'(cand);
      end
    end
  end

  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (IW'(i) == winner) word = src_data[i*W +: W];
    end
  end

  // Accept strobe exists only while idle and out of reset
  always_comb begin
    src_ready = '0;
    if (state == IDLE && found && !reset) src_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      xfer_req    <= 1'b0;
      xfer_data   <= '0;
      grant_id    <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      rr          <= IW'(N - 1);
      timer       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            xfer_data <= word;
            grant_id  <= winner;
            rr        <= winner;
            xfer_req  <= 1'b1;
            timer     <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            xfer_req <= 1'b0;
            state    <= REL;
          end else if (TIMEOUT != 0 && timer == TW'(TLAST)) begin
            xfer_req    <= 1'b0;
            timeout_err <= 1'b1;
            state       <= REL;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        REL: begin
          if (!ack_s) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
